bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble), one bit per clock.
//  Sits directly upstream of the per-digit 7-segment hex decoders.
//  Each 4-bit slice of bcd_out drives one decoder instance, showing decimal values
//  (note index, frequency, volume) on HEX displays.
//  Also produces a leading-zero mask so the top level can blank unused digits.
// PARAMETERS
//  BIN_W   16  width of binary input; also the number of SHIFT cycles per conversion
//  DIGITS  5   number of BCD digits produced (5 covers 0..65535 for BIN_W=16)
// PORTS
//  clk      in   1           system clock; all logic on rising edge
//  reset    in   1           synchronous, active-high reset
//  start    in   1           request a conversion of bin_in; sampled only in IDLE
//  bin_in   in   BIN_W       unsigned binary value; captured in the cycle start is accepted
//  busy     out  1           high from the cycle after acceptance until the cycle done is high, inclusive
//  done     out  1           one-cycle pulse: bcd_out/lz_mask/ovf valid and updated
//  bcd_out  out  4*DIGITS    registered BCD result; digit i = bcd_out[4i+3:4i]; held until next done
//  lz_mask  out  DIGITS      bit i=1 -> digit i and all higher digits are zero; bit 0 always 0
//  ovf      out  1           result exceeded 10^DIGITS-1; bcd_out holds truncated low digits
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, ovf=0, bcd_out=0.
//         lz_mask = {DIGITS-1{1'b1}},1'b0 (displays "0"). Internal shift/scratch/count cleared.
//  States:
//   IDLE -> SHIFT  when start=1
//     - load bin shift reg <= bin_in, scratch <= 0, count <= BIN_W, ovf_acc <= 0
//   SHIFT, each cycle:
//     - every scratch digit >= 5 gets +3
//     - then {scratch,binreg} shifts left by 1
//     - bit shifted out of the top digit is ORed into ovf_acc
//     - count decrements
//   SHIFT -> DONE  when count reaches 1 in this cycle (i.e. after BIN_W shifts)
//     - on the same edge: bcd_out <= final scratch, lz_mask and ovf <= ovf_acc registered
//   DONE -> IDLE unconditionally; done=1 only in DONE
//  Latency: start sampled at cycle 0 -> done=1 in cycle BIN_W+1 -> new start accepted in cycle BIN_W+2.
//  start while busy (SHIFT or DONE): ignored, not queued; bin_in changes mid-conversion have no effect.
//  start held high continuously: one conversion per BIN_W+2 cycles.
//  reset mid-conversion: abort immediately to reset values; no done pulse for the aborted request.
//  bcd_out, lz_mask and ovf change only on the edge entering DONE (glitch-free for the display).
//  Add-3 correction: applied per 4-bit digit, combinationally, before the shift; digits never exceed 9 after a shift.
//  lz_mask[i] (i>=1) = (digit i == 0) & lz_mask[i+1]; top bit = (digit DIGITS-1 == 0).
//  lz_mask is forced all-zero when ovf=1.
// STRUCTURE
//  Shared header synth_defs.vh:
//    - state encodings S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2
//    - BCD_ADJ_THRESH=4'd5, BCD_ADJ=4'd3
//  Sub-module bcd_add3 (4-bit in/out, combinational, +3 if >=5): one per digit via generate.
//  Top holds FSM, counter ($clog2(BIN_W+1) bits), shift/scratch regs, output registers.
// TESTING
//  1 reset, then start with bin_in=0:
//      done at cycle 17; bcd_out=20'h00000; lz_mask=5'b11110; ovf=0
//  2 bin_in=16'd1234:
//      bcd_out=20'h01234; lz_mask=5'b10000
//    bin_in=16'd65535 (next conversion):
//      bcd_out=20'h65535; lz_mask=5'b00000
//  3 start pulsed at cycles 3 and 10 after an accepted start (bin_in=42, then 999):
//      single done; bcd_out=20'h00042; busy high cycles 1..17
//  4 reset asserted at cycle 8 of a conversion of 500:
//      next cycle busy=0, done=0, bcd_out=0
//    later conversion of 77 -> 20'h00077
//  5 DIGITS=4 with bin_in=16'd10000:
//      ovf=1; bcd_out=16'h0000; lz_mask=4'b0000
//    then bin_in=9999 -> ovf=0, 16'h9999
//  6 start held high for 40 cycles with bin_in=7:
//      done pulses at cycles 17 and 35, each with bcd_out=20'h00007

Source files
------------

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared FSM encoding and BCD correction constants
// for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ        = 4'd3;

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Per-digit double-dabble correction:
// add 3 when the digit is 5 or more.
module bin_to_bcd_seq_add3
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= BCD_ADJ_THRESH) ? d + BCD_ADJ : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock,
// with a leading-zero mask for blanking display digits.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     lz_mask,
    output logic                  ovf
);

    localparam int CW = $clog2(BIN_W + 1);
    localparam int SW = 4 * DIGITS;

    state_t            state;
    logic [BIN_W-1:0]  binreg;
    logic [SW-1:0]     scratch;
    logic [SW-1:0]     adj;
    logic [SW-1:0]     scratch_n;
    logic [CW-1:0]     count;
    logic              ovf_acc;
    logic              ovf_n;
    logic [DIGITS-1:0] lz_n;
    logic              zrun;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bin_to_bcd_seq_add3 u_add3 (
            .d (scratch[4*g +: 4]),
            .q (adj[4*g +: 4])
        );
    end

    assign scratch_n = {adj[SW-2:0], binreg[BIN_W-1]};
    assign ovf_n     = ovf_acc | adj[SW-1];

    // Mask from the value being latched, so it lands with bcd_out.
    always_comb begin
        lz_n = '0;
        zrun = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zrun    = zrun & (scratch_n[4*i +: 4] == 4'd0);
            lz_n[i] = zrun;
        end
        if (ovf_n)
            lz_n = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            binreg  <= '0;
            scratch <= '0;
            count   <= '0;
            ovf_acc <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            lz_mask <= {{(DIGITS-1){1'b1}}, 1'b0};
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        binreg  <= bin_in;
                        scratch <= '0;
                        count   <= CW'(BIN_W);
                        ovf_acc <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    scratch <= scratch_n;
                    binreg  <= binreg << 1;
                    ovf_acc <= ovf_n;
                    count   <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        bcd_out <= scratch_n;
                        lz_mask <= lz_n;
                        ovf     <= ovf_n;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: table vectors, random values against an
// arithmetic model, and hand-written multi-cycle sequences.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] bin_in;

    logic        busy5, done5, ovf5;
    logic [19:0] bcd5;
    logic [4:0]  lz5;
    logic        busy4, done4, ovf4;
    logic [15:0] bcd4;
    logic [3:0]  lz4;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut5 (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy5),
        .done    (done5),
        .bcd_out (bcd5),
        .lz_mask (lz5),
        .ovf     (ovf5)
    );

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) dut4 (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy4),
        .done    (done4),
        .bcd_out (bcd4),
        .lz_mask (lz4),
        .ovf     (ovf4)
    );

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd5;
        logic [4:0]  lz5;
        logic        ovf5;
        logic [15:0] bcd4;
        logic [3:0]  lz4;
        logic        ovf4;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: decimal digits of v mod 10^d, overflow, blanking mask.
    task automatic model(input int v, input int d, output logic [19:0] bcd,
                         output logic [4:0] lz, output logic ov);
        int lim;
        int r;
        bit allz;
        lim  = 10 ** d;
        ov   = (v >= lim);
        r    = v % lim;
        bcd  = '0;
        lz   = '0;
        allz = 1'b1;
        for (int i = 0; i < d; i++)
            bcd[4*i +: 4] = 4'((r / (10 ** i)) % 10);
        for (int i = d - 1; i >= 1; i--) begin
            allz  = allz && (((r / (10 ** i)) % 10) == 0);
            lz[i] = allz;
        end
        if (ov)
            lz = '0;
    endtask

    task automatic convert(input logic [15:0] v, output int lat);
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bin_in = 16'($urandom);
        lat = -1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (done5) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ndone;
        int dcyc;
        int d2;
        int berr;
        logic [19:0] dbcd;
        logic [19:0] dbcd2;
        logic [19:0] mb;
        logic [4:0]  ml;
        logic        mo;
        logic [15:0] v;

        tbl[0] = '{16'd0,     20'h00000, 5'b11110, 1'b0, 16'h0000, 4'b1110, 1'b0};
        tbl[1] = '{16'd1234,  20'h01234, 5'b10000, 1'b0, 16'h1234, 4'b0000, 1'b0};
        tbl[2] = '{16'd65535, 20'h65535, 5'b00000, 1'b0, 16'h5535, 4'b0000, 1'b1};
        tbl[3] = '{16'd42,    20'h00042, 5'b11100, 1'b0, 16'h0042, 4'b1100, 1'b0};
        tbl[4] = '{16'd10000, 20'h10000, 5'b00000, 1'b0, 16'h0000, 4'b0000, 1'b1};
        tbl[5] = '{16'd9999,  20'h09999, 5'b10000, 1'b0, 16'h9999, 4'b0000, 1'b0};
        tbl[6] = '{16'd7,     20'h00007, 5'b11110, 1'b0, 16'h0007, 4'b1110, 1'b0};
        tbl[7] = '{16'd99999 % 65536, 20'h34463, 5'b00000, 1'b0,
                   16'h4463, 4'b0000, 1'b1};

        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy5), 32'd0);
        chk("rst_done", 32'(done5), 32'd0);
        chk("rst_bcd",  32'(bcd5),  32'd0);
        chk("rst_lz",   32'(lz5),   32'b11110);
        chk("rst_ovf",  32'(ovf5),  32'd0);
        chk("rst_lz4",  32'(lz4),   32'b1110);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            convert(tbl[i].bin, lat);
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd17);
            chk($sformatf("tbl%0d_bcd5", i), 32'(bcd5), 32'(tbl[i].bcd5));
            chk($sformatf("tbl%0d_lz5", i), 32'(lz5), 32'(tbl[i].lz5));
            chk($sformatf("tbl%0d_ovf5", i), 32'(ovf5), 32'(tbl[i].ovf5));
            chk($sformatf("tbl%0d_done4", i), 32'(done4), 32'd1);
            chk($sformatf("tbl%0d_bcd4", i), 32'(bcd4), 32'(tbl[i].bcd4));
            chk($sformatf("tbl%0d_lz4", i), 32'(lz4), 32'(tbl[i].lz4));
            chk($sformatf("tbl%0d_ovf4", i), 32'(ovf4), 32'(tbl[i].ovf4));
        end

        for (int i = 0; i < 40; i++) begin
            v = (i % 3 == 0) ? 16'($urandom_range(9000, 11000))
                             : 16'($urandom);
            convert(v, lat);
            chk("rnd_lat", 32'(lat), 32'd17);
            model(int'(v), 5, mb, ml, mo);
            chk($sformatf("rnd_bcd5(%0d)", v), 32'(bcd5), 32'(mb));
            chk($sformatf("rnd_lz5(%0d)", v), 32'(lz5), 32'(ml));
            chk($sformatf("rnd_ovf5(%0d)", v), 32'(ovf5), 32'(mo));
            model(int'(v), 4, mb, ml, mo);
            chk($sformatf("rnd_bcd4(%0d)", v), 32'(bcd4), 32'(mb[15:0]));
            chk($sformatf("rnd_lz4(%0d)", v), 32'(lz4), 32'(ml[3:0]));
            chk($sformatf("rnd_ovf4(%0d)", v), 32'(ovf4), 32'(mo));
        end

        // Extra start pulses while busy must be ignored.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd42;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        dcyc  = -1;
        berr  = 0;
        dbcd  = '0;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (busy5 !== (c <= 17))
                berr++;
            if (done5) begin
                ndone++;
                dcyc = c;
                dbcd = bcd5;
            end
            start  = (c == 3 || c == 10);
            bin_in = 16'd999;
        end
        start = 1'b0;
        chk("ign_ndone", 32'(ndone), 32'd1);
        chk("ign_dcyc",  32'(dcyc),  32'd17);
        chk("ign_bcd",   32'(dbcd),  32'h00042);
        chk("ign_busy",  32'(berr),  32'd0);

        // Reset mid-conversion aborts without a done pulse.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd500;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(busy5), 32'd0);
        chk("abort_done", 32'(done5), 32'd0);
        chk("abort_bcd",  32'(bcd5),  32'd0);
        chk("abort_lz",   32'(lz5),   32'b11110);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done5)
                ndone++;
        end
        chk("abort_nodone", 32'(ndone), 32'd0);
        convert(16'd77, lat);
        chk("after_lat", 32'(lat),  32'd17);
        chk("after_bcd", 32'(bcd5), 32'h00077);

        // Start held high: back-to-back conversions every 18 cycles.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 16'd7;
        @(posedge clk);
        ndone = 0;
        dcyc  = -1;
        d2    = -1;
        dbcd  = '1;
        dbcd2 = '1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done5) begin
                ndone++;
                if (ndone == 1) begin
                    dcyc = c;
                    dbcd = bcd5;
                end else begin
                    d2    = c;
                    dbcd2 = bcd5;
                end
            end
        end
        start = 1'b0;
        chk("hold_ndone", 32'(ndone), 32'd2);
        chk("hold_d1",    32'(dcyc),  32'd17);
        chk("hold_d2",    32'(d2),    32'd35);
        chk("hold_bcd1",  32'(dbcd),  32'h00007);
        chk("hold_bcd2",  32'(dbcd2), 32'h00007);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!busy5)
                break;
        end
        chk("drain_busy", 32'(busy5), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
